fifo_uart_tx: RTL and testbench

//  Downstream consumer of the byte FIFO: pops one word when the FIFO is non-empty and

---
 rtl/fifo_uart_tx.sv | 159 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Pops words from the byte FIFO and serialises them as UART frames (start, LSB-first data, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

    state_t                  state, state_n;
    logic [CW-1:0]           baud, baud_n;
    logic [BW-1:0]           bitc, bitc_n;
    logic [DATA_WIDTH-1:0]   shift, shift_n;
    logic                    rd_dly;
    logic                    baud_end;
    logic                    tx_n, busy_n, rd_n, done_n;
`ifdef UART_TX_PARITY_EN
    logic                    par, par_n;
`endif

    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bitc_n   = bitc;
        shift_n  = shift;
        rd_n     = 1'b0;
        baud_end = (baud == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        par_n    = par;
`endif
        case (state)
            IDLE: begin
                baud_n = '0;
                bitc_n = '0;
                if (!fifo_empty) begin
                    rd_n    = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                state_n = START;
            end
            START: begin
                // The pop is registered, so the word arrives during the first start-bit
                // cycle; CLKS_PER_BIT >= 2 guarantees it is latched before bit 0 goes out.
                if (rd_dly) begin
                    shift_n = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^fifo_dout;
`endif
                end
                if (baud_end) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (bitc == BIT_LAST) begin
                        bitc_n  = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bitc_n = bitc + 1'b1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_n  = '0;
                    state_n = STOP;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so the flops line up with the state.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
        done_n = (state_n == STOP) && (baud_n == BAUD_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud       <= '0;
            bitc       <= '0;
            shift      <= '0;
            rd_dly     <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            bitc       <= bitc_n;
            shift      <= shift_n;
            rd_dly     <= fifo_rd_en;
            fifo_rd_en <= rd_n;
            tx         <= tx_n;
            busy       <= busy_n;
            tx_done    <= done_n;
`ifdef UART_TX_PARITY_EN
            par        <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a queue-backed FIFO feeds the DUT and a UART
// frame decoder checks each frame against the pushed words.
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en, tx, busy, tx_done;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int viol   = 0;
    logic [DW-1:0] fq[$];

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    // FIFO model: read data valid only the cycle after a pop, garbage otherwise.
    always @(posedge clk) begin
        if (!rst && fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
        else fifo_dout <= DW'($urandom);
        fifo_empty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (!rst && fifo_rd_en) begin
            rd_cnt++;
            if (fifo_empty) viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push(input logic [DW-1:0] w);
        @(negedge clk);
        fq.push_back(w);
    endtask

    // Waits for a start bit, then samples every cycle of the frame.
    task automatic get_frame(input int limit, output int gap, output bit tmo,
                             output logic [DW-1:0] d, output logic pb, output logic sb,
                             output logic eb, output bit st, output bit dk, output bit bk);
        logic [NB-1:0] bits;
        gap = 0; tmo = 0; st = 1; dk = 1; bk = 1;
        bits = '0; d = '0; pb = 1'b0; sb = 1'b0; eb = 1'b0;
        @(negedge clk);
        while (tx !== 1'b0 && gap < limit) begin
            gap++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            tmo = 1;
            return;
        end
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (c == 0) bits[b] = tx;
                else if (tx !== bits[b]) st = 0;
                if (tx_done !== ((b == NB - 1) && (c == CPB - 1))) dk = 0;
                if (busy !== 1'b1) bk = 0;
            end
        end
        sb = bits[0];
        d  = bits[DW:1];
        eb = bits[NB-1];
`ifdef UART_TX_PARITY_EN
        pb = bits[DW+1];
`endif
    endtask

    function automatic logic exp_par(input logic [DW-1:0] w);
`ifdef UART_TX_PARITY_EN
        return ^w;
`else
        return 1'b0 & w[0];
`endif
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        fq.push_back(8'h3C);
        fq.push_back(8'hC3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, fifo_rd_en, tx_done} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_outputs: cycle %0d tx/busy/rd/done=%b required 1000",
                         i, {tx, busy, fifo_rd_en, tx_done});
            end
        end
        fq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_pop: rd pulses %0d required 0", rd_cnt);
        end
    endtask

    task automatic test_single;
        int gap, r0; bit tmo, st, dk, bk; logic [DW-1:0] d; logic pb, sb, eb;
        r0 = rd_cnt;
        push(8'hA5);
        get_frame(40, gap, tmo, d, pb, sb, eb, st, dk, bk);
        checks++;
        if (tmo || d !== 8'hA5 || sb !== 1'b0 || eb !== 1'b1 || pb !== exp_par(8'hA5) || !st || !dk || !bk) begin
            errors++;
            $display("FAIL single_frame: tmo=%0d data=%h start=%b stop=%b par=%b stable=%0d done_ok=%0d busy_ok=%0d required data=a5 start=0 stop=1",
                     tmo, d, sb, eb, pb, st, dk, bk);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL single_after: busy=%b tx=%b done=%b required 0 1 0", busy, tx, tx_done);
        end
        checks++;
        if (rd_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL single_rd_pulses: got %0d required 1", rd_cnt - r0);
        end
    endtask

    task automatic test_back_to_back;
        int gap, r0; bit tmo, st, dk, bk; logic [DW-1:0] d; logic pb, sb, eb;
        logic [DW-1:0] w[2];
        w[0] = 8'h01; w[1] = 8'h80;
        r0 = rd_cnt;
        @(negedge clk);
        fq.push_back(w[0]);
        fq.push_back(w[1]);
        for (int i = 0; i < 2; i++) begin
            get_frame(40, gap, tmo, d, pb, sb, eb, st, dk, bk);
            checks++;
            if (tmo || d !== w[i] || sb !== 1'b0 || eb !== 1'b1 || pb !== exp_par(w[i]) || !st || !dk || !bk) begin
                errors++;
                $display("FAIL b2b_frame%0d: tmo=%0d data=%h start=%b stop=%b stable=%0d done_ok=%0d busy_ok=%0d required data=%h",
                         i, tmo, d, sb, eb, st, dk, bk, w[i]);
            end
            if (i == 1) begin
                checks++;
                if (gap !== 2) begin
                    errors++;
                    $display("FAIL b2b_gap: idle cycles %0d required 2", gap);
                end
            end
        end
        checks++;
        if (rd_cnt - r0 !== 2) begin
            errors++;
            $display("FAIL b2b_rd_pulses: got %0d required 2", rd_cnt - r0);
        end
    endtask

    task automatic test_empty_hold;
        int r0;
        r0 = rd_cnt;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL empty_hold: cycle %0d rd=%b tx=%b busy=%b required 0 1 0",
                         i, fifo_rd_en, tx, busy);
            end
        end
        checks++;
        if (rd_cnt !== r0) begin
            errors++;
            $display("FAIL empty_rd_pulses: got %0d required 0", rd_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int gap, r0, n; bit tmo, st, dk, bk; logic [DW-1:0] d; logic pb, sb, eb;
        r0 = rd_cnt;
        push(8'hFF);
        n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL midrst_start: tx=%b never went low required 0", tx);
        end
        repeat (CPB * 4 + 1) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({tx, busy, fifo_rd_en, tx_done} !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_abort: tx/busy/rd/done=%b required 1000",
                     {tx, busy, fifo_rd_en, tx_done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(8'h5A);
        get_frame(40, gap, tmo, d, pb, sb, eb, st, dk, bk);
        checks++;
        if (tmo || d !== 8'h5A || sb !== 1'b0 || eb !== 1'b1 || pb !== exp_par(8'h5A) || !st || !dk || !bk) begin
            errors++;
            $display("FAIL midrst_frame: tmo=%0d data=%h start=%b stop=%b stable=%0d done_ok=%0d busy_ok=%0d required data=5a",
                     tmo, d, sb, eb, st, dk, bk);
        end
        checks++;
        if (rd_cnt - r0 !== 2) begin
            errors++;
            $display("FAIL midrst_rd_pulses: got %0d required 2", rd_cnt - r0);
        end
    endtask

    task automatic test_random;
        int gap, r0; bit tmo, st, dk, bk; logic [DW-1:0] d, w; logic pb, sb, eb;
        logic [DW-1:0] exp_q[$];
        r0 = rd_cnt;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            w = DW'($urandom);
            fq.push_back(w);
            exp_q.push_back(w);
        end
        for (int i = 0; i < 10; i++) begin
            if (i >= 5) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                w = DW'($urandom);
                push(w);
                exp_q.push_back(w);
            end
            w = exp_q.pop_front();
            get_frame(60, gap, tmo, d, pb, sb, eb, st, dk, bk);
            checks++;
            if (tmo || d !== w || sb !== 1'b0 || eb !== 1'b1 || pb !== exp_par(w) || !st || !dk || !bk) begin
                errors++;
                $display("FAIL rand_frame%0d: tmo=%0d data=%h par=%b start=%b stop=%b stable=%0d done_ok=%0d busy_ok=%0d required data=%h par=%b",
                         i, tmo, d, pb, sb, eb, st, dk, bk, w, exp_par(w));
            end
            if (i > 0 && i < 5) begin
                checks++;
                if (gap !== 2) begin
                    errors++;
                    $display("FAIL rand_gap%0d: idle cycles %0d required 2", i, gap);
                end
            end
        end
        checks++;
        if (rd_cnt - r0 !== 10 || viol !== 0) begin
            errors++;
            $display("FAIL rand_rd_pulses: got %0d (while empty %0d) required 10 (0)", rd_cnt - r0, viol);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        int gap; bit tmo, st, dk, bk; logic [DW-1:0] d; logic pb, sb, eb;
        logic [DW-1:0] w[2];
        logic          p[2];
        w[0] = 8'h07; p[0] = 1'b1;
        w[1] = 8'h03; p[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(w[i]);
            get_frame(40, gap, tmo, d, pb, sb, eb, st, dk, bk);
            checks++;
            if (tmo || d !== w[i] || pb !== p[i] || sb !== 1'b0 || eb !== 1'b1 || !st || !dk || !bk) begin
                errors++;
                $display("FAIL parity_frame%0d: tmo=%0d data=%h par=%b stop=%b done_ok=%0d required data=%h par=%b",
                         i, tmo, d, pb, eb, dk, w[i], p[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_empty_hold;
        test_reset_mid_frame;
        test_random;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL rd_while_empty: got %0d required 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
